// File: rtl/lzs_pkg.sv
// Shared constants for the LZS encoder output path: code/word geometry,
// the accept threshold and the packer state encoding.
package lzs_pkg;
   localparam int unsigned CODE_W     = 13;
   localparam int unsigned WIDTH_W    = 4;
   localparam int unsigned WORD_W     = 64;
   localparam int unsigned ACC_W      = 2 * WORD_W;
   // Highest bit count that still has room for a maximum-width code.
   localparam int unsigned ACCEPT_MAX = ACC_W - CODE_W;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_FLUSH = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;
endpackage

// File: rtl/encode_out_acc.sv
// 128-bit MSB-first bit accumulator: optional shift by one word, then
// OR-in of a masked code directly below the surviving valid bits.
module encode_out_acc
   import lzs_pkg::*;
#(
   parameter int unsigned IN_WIDTH       = CODE_W,
   parameter int unsigned NEED_STR_WIDTH = WIDTH_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr_i,
   input  logic                      shift_i,
   input  logic                      append_i,
   input  logic [7:0]                base_i,
   input  logic [IN_WIDTH-1:0]       code_i,
   input  logic [NEED_STR_WIDTH-1:0] width_i,
   output logic [WORD_W-1:0]         word_o
);
   logic [ACC_W-1:0] acc_q, acc_d, shifted, ins;
   logic [7:0]       pos;

   // Bits below the valid region are always zero, so OR-insertion is safe
   // and the top word is already zero-padded for the final flush word.
   always_comb begin
      shifted = shift_i ? {acc_q[ACC_W-WORD_W-1:0], {WORD_W{1'b0}}} : acc_q;
      pos     = 8'(ACC_W) - base_i - 8'(width_i);
      ins     = {{(ACC_W-IN_WIDTH){1'b0}}, code_i} << pos;
      acc_d   = append_i ? (shifted | ins) : shifted;
      if (clr_i) acc_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) acc_q <= '0;
      else     acc_q <= acc_d;
   end

   assign word_o = acc_q[ACC_W-1 -: WORD_W];
endmodule

// File: rtl/encode_out.sv
// LZS encoder output packer: variable-width codes packed MSB-first into
// 64-bit FIFO words, with a zero-padded final word on flush.
module encode_out
   import lzs_pkg::*;
#(
   parameter int unsigned IN_WIDTH       = CODE_W,
   parameter int unsigned NEED_STR_WIDTH = WIDTH_W,
   parameter int unsigned LZF_WIDTH      = 20
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [IN_WIDTH-1:0]       code_data,
   input  logic [NEED_STR_WIDTH-1:0] code_width,
   input  logic                      code_valid,
   output logic                      code_ack,
   input  logic                      flush,
   input  logic                      fo_full,
   output logic [WORD_W-1:0]         fo_data,
   output logic                      fo_valid,
   output logic                      fo_last,
   output logic                      done,
   output logic [LZF_WIDTH-1:0]      word_cnt
);
   localparam logic [NEED_STR_WIDTH-1:0] MAX_W   = NEED_STR_WIDTH'(IN_WIDTH);
   localparam logic [7:0]                ACC_LIM = 8'(ACCEPT_MAX);
   localparam logic [7:0]                WORD_BITS = 8'(WORD_W);

   logic [1:0]                state_q, state_d;
   logic [7:0]                cnt_q, cnt_d, base;
   logic [WORD_W-1:0]         fo_data_q, fo_data_d, acc_word;
   logic                      fo_valid_q, fo_last_q, done_q;
   logic                      pending_q, pending_d;
   logic [LZF_WIDTH-1:0]      word_cnt_q, word_cnt_d;
   logic [NEED_STR_WIDTH-1:0] eff_w;
   logic [IN_WIDTH-1:0]       code_mask, code_masked;
   logic                      ack, emit, emit_last;

   always_comb begin
      eff_w       = (code_width > MAX_W) ? MAX_W : code_width;
      code_mask   = ~({IN_WIDTH{1'b1}} << eff_w);
      code_masked = code_data & code_mask;

      ack       = code_valid & (state_q == ST_RUN) & (cnt_q <= ACC_LIM);
      emit      = (state_q != ST_DONE) & (cnt_q >= WORD_BITS) & ~fo_full;
      emit_last = (state_q == ST_FLUSH) & (cnt_q != 8'd0) & (cnt_q < WORD_BITS) & ~fo_full;

      base  = emit ? (cnt_q - WORD_BITS) : cnt_q;
      cnt_d = base + (ack ? 8'(eff_w) : 8'd0);
      if (emit_last) cnt_d = 8'd0;

      state_d = state_q;
      case (state_q)
         ST_RUN:   if (flush) state_d = ST_FLUSH;
         ST_FLUSH: if (emit_last || (cnt_q == 8'd0)) state_d = ST_DONE;
         ST_DONE:  state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase

      fo_data_d = (emit || emit_last) ? acc_word : fo_data_q;

      // The stream counter survives DONE and restarts with the next stream.
      pending_d = pending_q;
      if (state_q == ST_DONE) pending_d = 1'b1;
      else if (ack)           pending_d = 1'b0;

      word_cnt_d = (ack && pending_q) ? '0 : word_cnt_q;
      if (emit || emit_last) word_cnt_d = word_cnt_q + LZF_WIDTH'(1);
   end

   encode_out_acc #(
      .IN_WIDTH       (IN_WIDTH),
      .NEED_STR_WIDTH (NEED_STR_WIDTH)
   ) u_acc (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (emit_last),
      .shift_i  (emit),
      .append_i (ack),
      .base_i   (base),
      .code_i   (code_masked),
      .width_i  (eff_w),
      .word_o   (acc_word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_RUN;
         cnt_q      <= '0;
         fo_data_q  <= '0;
         fo_valid_q <= 1'b0;
         fo_last_q  <= 1'b0;
         done_q     <= 1'b0;
         pending_q  <= 1'b0;
         word_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         fo_data_q  <= fo_data_d;
         fo_valid_q <= emit | emit_last;
         fo_last_q  <= emit_last;
         done_q     <= (state_q == ST_DONE);
         pending_q  <= pending_d;
         word_cnt_q <= word_cnt_d;
      end
   end

   assign code_ack = ack;
   assign fo_data  = fo_data_q;
   assign fo_valid = fo_valid_q;
   assign fo_last  = fo_last_q;
   assign done     = done_q;
   assign word_cnt = word_cnt_q;
endmodule

// File: tb/tb_encode_out.sv
// Directed bench for encode_out: packing, flush padding, back-pressure,
// width rules, word counting and mid-stream reset.
module tb_encode_out;
   logic        clk = 1'b0;
   logic        rst;
   logic [12:0] code_data;
   logic [3:0]  code_width;
   logic        code_valid;
   logic        code_ack;
   logic        flush;
   logic        fo_full;
   logic [63:0] fo_data;
   logic        fo_valid;
   logic        fo_last;
   logic        done;
   logic [19:0] word_cnt;

   int checks   = 0;
   int failures = 0;

   logic [63:0] wq_data[$];
   bit          wq_last[$];
   logic [19:0] wq_cnt[$];
   int          wq_cyc[$];
   int          cyc_no   = 0;
   int          done_cnt = 0;
   int          done_cyc = 0;

   encode_out #(
      .IN_WIDTH       (13),
      .NEED_STR_WIDTH (4),
      .LZF_WIDTH      (20)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .code_data  (code_data),
      .code_width (code_width),
      .code_valid (code_valid),
      .code_ack   (code_ack),
      .flush      (flush),
      .fo_full    (fo_full),
      .fo_data    (fo_data),
      .fo_valid   (fo_valid),
      .fo_last    (fo_last),
      .done       (done),
      .word_cnt   (word_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc_no <= cyc_no + 1;
      if (fo_valid) begin
         wq_data.push_back(fo_data);
         wq_last.push_back(fo_last);
         wq_cnt.push_back(word_cnt);
         wq_cyc.push_back(cyc_no);
      end
      if (done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc_no;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_q();
      wq_data.delete();
      wq_last.delete();
      wq_cnt.delete();
      wq_cyc.delete();
   endtask

   task automatic send(input logic [3:0] w, input logic [12:0] d);
      bit ok;
      ok = 0;
      code_width = w;
      code_data  = d;
      code_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (code_ack) ok = 1;
         @(posedge clk);
         #1;
      end
      code_valid = 1'b0;
      if (!ok) chk("send_timeout", 64'(ok), 64'd1);
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int  d0;
      bit  seen;
      d0   = done_cnt;
      seen = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (done_cnt != d0) seen = 1;
      end
      chk({tag, "_done_seen"}, 64'(seen), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_done_pulse"}, 64'(done_cnt - d0), 64'd1);
   endtask

   // Single-word stream check: word count, data, last flag, counter.
   task automatic chk_one(input string tag, input logic [63:0] d, input bit last);
      chk({tag, "_nwords"}, 64'(wq_data.size()), 64'd1);
      if (wq_data.size() >= 1) begin
         chk({tag, "_data"}, wq_data[0], d);
         chk({tag, "_last"}, 64'(wq_last[0]), 64'(last));
         chk({tag, "_wcnt"}, 64'(wq_cnt[0]), 64'd1);
      end
   endtask

   bit          bits[0:511];
   int          nbits;
   logic [12:0] codes[0:19];

   initial begin
      int          idx, cyc, pre_ack, nw;
      bit          seen_done, acked;
      logic [63:0] w;

      rst = 1'b1; code_data = '0; code_width = '0; code_valid = 1'b0;
      flush = 1'b0; fo_full = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_fo_valid", 64'(fo_valid), 64'd0);
      chk("rst_fo_data",  fo_data, 64'd0);
      chk("rst_fo_last",  64'(fo_last), 64'd0);
      chk("rst_done",     64'(done), 64'd0);
      chk("rst_word_cnt", 64'(word_cnt), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Eight bytes fill exactly one word; the flush then adds nothing.
      clear_q();
      for (int i = 1; i <= 8; i++) send(4'd8, 13'(i));
      repeat (3) @(posedge clk);
      #1;
      chk_one("pack8", 64'h0102030405060708, 1'b0);
      pulse_flush();
      wait_done("pack8");
      chk("pack8_nopad", 64'(wq_data.size()), 64'd1);

      // One 9-bit code, flushed into a padded word; done follows a cycle later.
      clear_q();
      send(4'd9, 13'h1A5);
      pulse_flush();
      wait_done("nine");
      chk_one("nine", 64'hD280000000000000, 1'b1);
      if (wq_cyc.size() >= 1) chk("nine_done_lat", 64'(done_cyc - wq_cyc[0]), 64'd1);

      // Code and flush together; a following code must wait for done.
      clear_q();
      code_width = 4'd5; code_data = 13'h1F; code_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      chk("cflush_ack", 64'(code_ack), 64'd1);
      @(posedge clk);
      #1;
      flush = 1'b0;
      code_width = 4'd8; code_data = 13'h33;
      pre_ack = 0; seen_done = 0; acked = 0;
      for (int i = 0; i < 100 && !acked; i++) begin
         @(negedge clk);
         if (done) seen_done = 1;
         if (code_ack) begin
            acked = 1;
            if (!seen_done) pre_ack++;
         end
         @(posedge clk);
         #1;
      end
      code_valid = 1'b0;
      chk("cflush_pre_ack", 64'(pre_ack), 64'd0);
      chk("cflush_later_ack", 64'(acked), 64'd1);
      chk_one("cflush", 64'hF800000000000000, 1'b1);
      clear_q();
      pulse_flush();
      wait_done("after");
      chk_one("after", 64'h3300000000000000, 1'b1);

      // Width rules: masking above width, zero width, 15 clamps to 13.
      clear_q();
      send(4'd4,  13'h1FF5);
      send(4'd0,  13'h1FFF);
      send(4'd15, 13'h1ABC);
      send(4'd3,  13'h1FFB);
      pulse_flush();
      wait_done("widths");
      chk_one("widths", 64'h5D5E300000000000, 1'b1);

      // Back-pressure: continuous 13-bit codes with the FIFO held full.
      clear_q();
      nbits = 0;
      for (int i = 0; i < 20; i++) begin
         codes[i] = 13'((i * 32'h0357 + 32'h0A5A) & 32'h1FFF);
         for (int b = 12; b >= 0; b--) begin
            bits[nbits] = codes[i][b];
            nbits++;
         end
      end
      fo_full = 1'b1;
      idx = 0; cyc = 0;
      while (idx < 20 && cyc < 1000) begin
         code_valid = 1'b1; code_width = 4'd13; code_data = codes[idx];
         @(negedge clk);
         if (code_ack) idx++;
         cyc++;
         if (cyc == 15) begin
            chk("full_acks", 64'(idx), 64'd9);
            chk("full_nowords", 64'(wq_data.size()), 64'd0);
         end
         @(posedge clk);
         #1;
         if (cyc == 15) fo_full = 1'b0;
      end
      code_valid = 1'b0;
      chk("stream_all_acked", 64'(idx), 64'd20);
      pulse_flush();
      wait_done("stream");
      nw = (nbits + 63) / 64;
      chk("stream_nwords", 64'(wq_data.size()), 64'(nw));
      for (int k = 0; k < nw && k < wq_data.size(); k++) begin
         w = '0;
         for (int b = 0; b < 64; b++)
            if (k * 64 + b < nbits) w[63-b] = bits[k*64+b];
         chk($sformatf("stream_w%0d", k), wq_data[k], w);
         chk($sformatf("stream_l%0d", k), 64'(wq_last[k]), 64'((k == nw - 1) && (nbits % 64 != 0)));
         chk($sformatf("stream_c%0d", k), 64'(wq_cnt[k]), 64'(k + 1));
      end

      // Reset with 40 bits buffered discards them without a write.
      clear_q();
      for (int i = 0; i < 5; i++) send(4'd8, 13'(8'h11 + i));
      rst = 1'b1;
      #2;
      chk("mrst_fo_valid", 64'(fo_valid), 64'd0);
      chk("mrst_fo_data",  fo_data, 64'd0);
      chk("mrst_fo_last",  64'(fo_last), 64'd0);
      chk("mrst_done",     64'(done), 64'd0);
      chk("mrst_word_cnt", 64'(word_cnt), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("mrst_nowords", 64'(wq_data.size()), 64'd0);
      send(4'd8, 13'h0AA);
      pulse_flush();
      wait_done("mrst");
      chk_one("mrst", 64'hAA00000000000000, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
